// File: rtl/t02_ram_responder.sv
// Word-addressed on-chip RAM responder for the team-02 Ren/Wen memory bus.
// Each request is latched, held busy for LATENCY cycles, then committed in a one-cycle DONE state.
module t02_ram_responder #(
  parameter int          ADDR_W    = 10,
  parameter int          LATENCY   = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        Ren,
  input  logic        Wen,
  input  logic [31:0] ramaddr,
  input  logic [31:0] ramstore,
  output logic [31:0] ramload,
  output logic        busy_o,
  output logic        err_o
);

  localparam int          DEPTH     = 2 ** ADDR_W;
  localparam logic [29:0] BASE_WORD = BASE_ADDR[31:2];
  localparam logic [3:0]  CNT_INIT  = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;
  localparam bit          HAS_WAIT  = (LATENCY > 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state;
  state_t next_state;
  logic [3:0] cnt;
  logic [3:0] next_cnt;
  logic       capture;
  logic       commit;

  logic [31:0] mem [DEPTH];

  // Captured transaction
  logic              cap_wr;
  logic              cap_ok;
  logic              cap_both;
  logic [ADDR_W-1:0] cap_idx;
  logic [31:0]       cap_data;

  // Live decode of the bus; base is word aligned, so word offsets equal off[31:2]
  logic [29:0]       word_off;
  logic              live_ok;
  logic [ADDR_W-1:0] live_idx;

  assign word_off = ramaddr[31:2] - BASE_WORD;
  assign live_ok  = (ramaddr >= BASE_ADDR) && (word_off[29:ADDR_W] == {(30 - ADDR_W){1'b0}});
  assign live_idx = word_off[ADDR_W-1:0];

  // The commit edge leaving IDLE (LATENCY == 1) uses the live bus, otherwise the capture
  logic              src_wr;
  logic              src_ok;
  logic              src_both;
  logic [ADDR_W-1:0] src_idx;
  logic [31:0]       src_data;

  // Select the source of the transaction being committed
  always_comb begin
    if (state == S_IDLE) begin
      src_wr   = Wen;
      src_ok   = live_ok;
      src_both = Ren & Wen;
      src_idx  = live_idx;
      src_data = ramstore;
    end else begin
      src_wr   = cap_wr;
      src_ok   = cap_ok;
      src_both = cap_both;
      src_idx  = cap_idx;
      src_data = cap_data;
    end
  end

  // State and latency counter register
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  // Next-state, busy and capture/commit strobes
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    busy_o     = 1'b0;
    capture    = 1'b0;
    commit     = 1'b0;
    case (state)
      S_IDLE: begin
        busy_o = Ren | Wen;
        if (Ren | Wen) begin
          capture = 1'b1;
          if (HAS_WAIT) begin
            next_state = S_WAIT;
            next_cnt   = CNT_INIT;
          end else begin
            next_state = S_DONE;
            commit     = 1'b1;
          end
        end else begin
          next_state = S_IDLE;
        end
      end
      S_WAIT: begin
        busy_o = 1'b1;
        if (cnt == 4'd0) begin
          next_state = S_DONE;
          commit     = 1'b1;
        end else begin
          next_cnt = cnt - 4'd1;
        end
      end
      S_DONE: begin
        next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
        next_cnt   = 4'd0;
      end
    endcase
  end

  // Capture register, read-data register and error pulse
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      cap_wr   <= 1'b0;
      cap_ok   <= 1'b0;
      cap_both <= 1'b0;
      cap_idx  <= {ADDR_W{1'b0}};
      cap_data <= 32'h0000_0000;
      ramload  <= 32'h0000_0000;
      err_o    <= 1'b0;
    end else begin
      if (capture) begin
        cap_wr   <= Wen;
        cap_ok   <= live_ok;
        cap_both <= Ren & Wen;
        cap_idx  <= live_idx;
        cap_data <= ramstore;
      end
      if (commit && !src_wr) begin
        ramload <= src_ok ? mem[src_idx] : 32'h0000_0000;
      end
      err_o <= commit & (~src_ok | src_both);
    end
  end

  // Storage is never reset; a reset on the commit edge suppresses the write
  always_ff @(posedge CLK) begin
    if (nRST && commit && src_wr && src_ok) begin
      mem[src_idx] <= src_data;
    end
  end

endmodule

// File: tb/tb_t02_ram_responder.sv
// Self-checking bench for t02_ram_responder: LATENCY=2 and LATENCY=1 instances,
// table-driven accesses with a scoreboard queue plus hand-written corner sequences.
module tb_t02_ram_responder;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        nRST;
  logic        ren0, wen0, busy0, err0;
  logic [31:0] addr0, store0, load0;
  logic        ren1, wen1, busy1, err1;
  logic [31:0] addr1, store1, load1;

  t02_ram_responder #(.ADDR_W(10), .LATENCY(2), .BASE_ADDR(32'h0000_0000)) dut (
    .CLK(CLK), .nRST(nRST), .Ren(ren0), .Wen(wen0), .ramaddr(addr0), .ramstore(store0),
    .ramload(load0), .busy_o(busy0), .err_o(err0)
  );

  t02_ram_responder #(.ADDR_W(10), .LATENCY(1), .BASE_ADDR(32'h0000_0000)) dut1 (
    .CLK(CLK), .nRST(nRST), .Ren(ren1), .Wen(wen1), .ramaddr(addr1), .ramstore(store1),
    .ramload(load1), .busy_o(busy1), .err_o(err1)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] ld;
    bit          chk_ld;
    bit          err;
    int          busy;
  } exp_t;

  typedef struct {
    bit          r;
    bit          w;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] ld;
    bit          chk_ld;
    bit          err;
  } vec_t;

  exp_t sb[$];
  vec_t vt[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  task automatic drive(input bit which, input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
    if (which) begin
      ren1 = r; wen1 = w; addr1 = a; store1 = d;
    end else begin
      ren0 = r; wen0 = w; addr0 = a; store0 = d;
    end
  endtask

  function automatic logic get_busy(input bit which);
    return which ? busy1 : busy0;
  endfunction

  function automatic logic get_err(input bit which);
    return which ? err1 : err0;
  endfunction

  function automatic logic [31:0] get_load(input bit which);
    return which ? load1 : load0;
  endfunction

  // Drive one request, count busy cycles, check completion against the scoreboard head.
  task automatic access(input bit which, input bit r, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input string nm);
    exp_t        e;
    int          nb;
    bit          got;
    logic [31:0] ld;
    logic        er;
    nb = 0; got = 1'b0; ld = 32'h0; er = 1'b0;
    drive(which, r, w, a, d);
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge CLK);
      if (get_busy(which)) nb++;
      else begin
        got = 1'b1;
        ld  = get_load(which);
        er  = get_err(which);
      end
    end
    drive(which, 1'b0, 1'b0, a, d);
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL %s: scoreboard empty", nm);
    end else begin
      e = sb.pop_front();
      chk({nm, " done"}, 32'(got), 32'd1);
      chk({nm, " busy_cycles"}, 32'(nb), 32'(e.busy));
      if (e.chk_ld) chk({nm, " ramload"}, ld, e.ld);
      chk({nm, " err"}, {31'd0, er}, {31'd0, e.err});
    end
    @(posedge CLK); #1;
    chk({nm, " err_after"}, {31'd0, get_err(which)}, 32'd0);
  endtask

  initial begin
    int c0;
    vt[0] = '{1'b0, 1'b1, 32'h0000_0000, 32'h0000_0111, 32'h0,         1'b0, 1'b0};
    vt[1] = '{1'b0, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0,         1'b0, 1'b0};
    vt[2] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,         32'hDEAD_BEEF, 1'b1, 1'b0};
    vt[3] = '{1'b1, 1'b0, 32'h0000_1000, 32'h0,         32'h0,         1'b1, 1'b1};
    vt[4] = '{1'b0, 1'b1, 32'h0000_1000, 32'h1234_5678, 32'h0,         1'b1, 1'b1};
    vt[5] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         32'h0000_0111, 1'b1, 1'b0};
    vt[6] = '{1'b1, 1'b1, 32'h0000_0008, 32'hA5A5_A5A5, 32'h0000_0111, 1'b1, 1'b1};
    vt[7] = '{1'b1, 1'b0, 32'h0000_0008, 32'h0,         32'hA5A5_A5A5, 1'b1, 1'b0};
    vt[8] = '{1'b0, 1'b1, 32'h0000_0020, 32'hCAFE_0020, 32'hA5A5_A5A5, 1'b1, 1'b0};
    vt[9] = '{1'b0, 1'b1, 32'h0000_0024, 32'h0BAD_0024, 32'hA5A5_A5A5, 1'b1, 1'b0};

    nRST = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst ramload0", load0, 32'h0);
    chk("rst busy0", {31'd0, busy0}, 32'd0);
    chk("rst err0", {31'd0, err0}, 32'd0);
    chk("rst ramload1", load1, 32'h0);
    chk("rst busy1", {31'd0, busy1}, 32'd0);
    chk("rst err1", {31'd0, err1}, 32'd0);
    @(posedge CLK); #1;
    nRST = 1'b1;

    // First post-reset cycle: busy must rise with the request itself
    sb.push_back('{32'h0, 1'b0, 1'b0, 2});
    access(1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'h0, "first_rd");

    for (int i = 0; i < 10; i++) begin
      sb.push_back('{vt[i].ld, vt[i].chk_ld, vt[i].err, 2});
      access(1'b0, vt[i].r, vt[i].w, vt[i].a, vt[i].d, $sformatf("vec%0d", i));
    end

    // Initiator switches to a write of 0x24 while the read of 0x20 is waiting
    drive(1'b0, 1'b1, 1'b0, 32'h0000_0020, 32'h0);
    @(negedge CLK);
    chk("switch busy T", {31'd0, busy0}, 32'd1);
    @(posedge CLK); #1;
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0024, 32'hFFFF_FFFF);
    @(negedge CLK);
    chk("switch busy T+1", {31'd0, busy0}, 32'd1);
    @(posedge CLK); #1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge CLK);
    chk("switch busy T+2", {31'd0, busy0}, 32'd0);
    chk("switch ramload", load0, 32'hCAFE_0020);
    @(posedge CLK); #1;
    sb.push_back('{32'h0BAD_0024, 1'b1, 1'b0, 2});
    access(1'b0, 1'b1, 1'b0, 32'h0000_0024, 32'h0, "rd24_untouched");

    // Reset in WAIT, on the commit edge of a write: write dropped, ramload cleared
    sb.push_back('{32'hDEAD_BEEF, 1'b1, 1'b0, 2});
    access(1'b0, 1'b1, 1'b0, 32'h0000_0040, 32'h0, "rd40_pre");
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0040, 32'h5555_5555);
    @(negedge CLK);
    chk("rstwait busy T", {31'd0, busy0}, 32'd1);
    @(posedge CLK); #1;
    nRST = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge CLK);
    chk("rstwait busy WAIT", {31'd0, busy0}, 32'd1);
    @(posedge CLK); #1;
    nRST = 1'b1;
    @(negedge CLK);
    chk("rstwait busy after", {31'd0, busy0}, 32'd0);
    chk("rstwait ramload", load0, 32'h0);
    chk("rstwait err", {31'd0, err0}, 32'd0);
    @(posedge CLK); #1;
    sb.push_back('{32'hDEAD_BEEF, 1'b1, 1'b0, 2});
    access(1'b0, 1'b1, 1'b0, 32'h0000_0040, 32'h0, "rd40_post");

    // LATENCY=1: preload four words, then four back-to-back reads in eight cycles
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{32'h0, 1'b1, 1'b0, 1});
      access(1'b1, 1'b0, 1'b1, 32'(4 * i), 32'h1000_0000 + 32'(i), $sformatf("l1_wr%0d", i));
    end
    c0 = cyc;
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{32'h1000_0000 + 32'(i), 1'b1, 1'b0, 1});
      access(1'b1, 1'b1, 1'b0, 32'(4 * i), 32'h0, $sformatf("l1_rd%0d", i));
    end
    chk("l1 cycles", 32'(cyc - c0), 32'd8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/t02_ram_responder.md
# t02_ram_responder

Word-addressed on-chip RAM that answers the `Ren`/`Wen`/`ramaddr`/`ramstore` → `ramload`/`busy_o` bus driven by the team-02 memory request path. It is the responder end of that bus. It latches one request, holds `busy_o` high for a fixed programmable latency, then commits the write or returns read data. It replaces the external RAM model in the team-02 integration bench and in the standalone core configuration.

## Interface
- `ADDR_W`, 10 — log2 of depth in 32-bit words; `DEPTH = 2**ADDR_W`.
- `LATENCY`, 2 — busy cycles per access; legal range 1..15.
- `BASE_ADDR`, 32'h0000_0000 — byte address of word 0; must be 4-byte aligned.

- `CLK` in 1 — clock; all state updates on the rising edge.
- `nRST` in 1 — reset, synchronous, active-low.
- `Ren` in 1 — read request; held by the initiator until `busy_o` is seen low.
- `Wen` in 1 — write request; same hold rule.
- `ramaddr` in 32 — byte address; bits [1:0] ignored.
- `ramstore` in 32 — write data.
- `ramload` out 32 — read data; registered.
- `busy_o` out 1 — access in progress.
- `err_o` out 1 — one-cycle pulse marking a faulty access.

## Operation
- States: IDLE, WAIT, DONE. Capture-register fields: op (RD/WR), word index, data, range-ok flag, both-enables flag. Down-counter `cnt` is 4 bits.
- IDLE:
  - `busy_o = Ren | Wen` (combinational), so the initiator never sees a false ready in its request cycle.
  - If `Ren|Wen` is high, capture all fields. Go to WAIT with `cnt = LATENCY-2` if `LATENCY > 1`, else go directly to DONE.
- WAIT:
  - `busy_o = 1`. Inputs are ignored. `cnt` decrements.
  - At `cnt == 0`, go to DONE.
- DONE:
  - Lasts exactly one cycle, then returns to IDLE. `busy_o = 0`. Bus inputs are not sampled.
  - On entry (the same edge that leaves IDLE or WAIT):
    - In-range write: `mem[idx] <= data`.
    - In-range read: `ramload <= mem[idx]`.
    - Out-of-range read: `ramload <= 32'h0`.
  - `err_o = 1` during DONE if the access was out of range or both enables were high.
- Address decode:
  - `off = ramaddr - BASE_ADDR`, 32-bit unsigned.
  - In range iff `ramaddr >= BASE_ADDR` and `off[31:2] < DEPTH`.
  - `idx = off[ADDR_W+1:2]`.
- Both `Ren` and `Wen` high: the write is performed if in range, no read is done, `ramload` is unchanged, and `err_o` pulses.
- Out-of-range write: dropped; memory unchanged.
- `ramload` holds its value until the next completed read. Writes never disturb it.
- Initiator deasserting or changing the request during WAIT: ignored. The captured transaction completes unchanged.
- Memory array is not reset. Its contents survive `nRST`.

## Timing
- Reset (`nRST` low at an edge):
  - State goes to IDLE, `cnt = 0`, `ramload = 32'h0`, `err_o = 0`.
  - `busy_o` then follows the IDLE rule.
  - Any in-flight access is abandoned. If reset coincides with the DONE-entry edge, the write is not committed.
- Request first presented in cycle T, `LATENCY = L`:
  - `busy_o` is high in cycles T .. T+L-1 and low in T+L.
  - Read data is valid on `ramload` from T+L onward.
- Back-to-back: a new request presented in T+L+1 is captured in T+L+1. Throughput is one access per L+1 cycles.
- Read-after-write to the same word, back-to-back, returns the new data.
- Initiator rule: an access is complete in the first cycle `busy_o` is low after the request is raised. The initiator must present the next request no earlier than the following cycle.

## Test plan
- Reset, then idle with no request:
  - `ramload = 0`, `busy_o = 0`, `err_o = 0`.
  - Hold `Ren = 1` at address 0x10 in the first post-reset cycle: `busy_o` goes high in the same cycle.
- Write 32'hDEAD_BEEF to 0x0000_0040, then read 0x0000_0040 back-to-back with `LATENCY = 2`:
  - Each access shows `busy_o` pattern 1,1,0.
  - `ramload = 32'hDEAD_BEEF` in the read's DONE cycle.
  - `err_o` stays 0 throughout.
- Read 0x0000_1000 (`DEPTH = 1024`, out of range):
  - `ramload = 0` and `err_o` pulses for one cycle.
  - A write of 32'h1234_5678 to 0x1000 leaves word 0 unchanged.
- `Ren = Wen = 1` at 0x8 with `ramstore = 32'hA5A5_A5A5`:
  - `err_o` pulses and `ramload` keeps its prior value.
  - A later read of 0x8 returns 32'hA5A5_A5A5.
- Read of 0x20 is captured; the initiator switches to a write of 0x24 during WAIT:
  - The read of 0x20 completes normally and 0x24 is untouched.
  - Pull `nRST` low in WAIT of another access: `busy_o` drops the next cycle, `ramload = 0`, and memory is intact.
- `LATENCY = 1`, 4 back-to-back reads at 0x0, 0x4, 0x8, 0xC:
  - `busy_o` pattern is 1,0 per access.
  - The 4 reads complete in 8 cycles with correct data.
